// File: rtl/pc_im.sv
// Instruction-fetch front end: 10-bit program counter addressing a 1024 x 16 instruction
// memory with an asynchronous read port and a synchronous write port at the current PC.
module pc_im #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] br_address,
  input  logic                  en_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] instr_address,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // Zero-initialised so simulation starts from a clean image; reset never clears it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Stall outranks branch; increment wraps naturally at the register width.
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(1);
    if (stall) begin
      pc_d = pc_q;
    end else if (branch) begin
      pc_d = br_address;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Write lands at the pre-edge PC regardless of reset or stall.
  always_ff @(posedge clk) begin
    if (en_write) begin
      mem_q[pc_q] <= data_in;
    end
  end

  assign instr_address = pc_q;
  assign data_out      = mem_q[pc_q];

endmodule

// File: tb/tb_pc_im.sv
// Scoreboard bench for pc_im: stimulus pushes the expected post-edge PC and read data,
// a monitor pops and compares one entry just after each rising edge.
module tb_pc_im;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        branch = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  br_address = '0;
  logic        en_write = 1'b0;
  logic [15:0] data_in = '0;
  logic [9:0]  instr_address;
  logic [15:0] data_out;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   stim_done = 1'b0;

  pc_im dut (
    .clk          (clk),
    .reset        (reset),
    .branch       (branch),
    .stall        (stall),
    .br_address   (br_address),
    .en_write     (en_write),
    .data_in      (data_in),
    .instr_address(instr_address),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  // Drive inputs for the next edge and record what the DUT must show after it.
  task automatic step(input logic rst, input logic st, input logic br, input logic [9:0] bra,
                      input logic we, input logic [15:0] din, input logic [9:0] ea,
                      input logic [15:0] ed, input string nm);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    stall      = st;
    branch     = br;
    br_address = bra;
    en_write   = we;
    data_in    = din;
    e.addr = ea;
    e.data = ed;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_address === e.addr) passed++;
        else $display("FAIL %s addr: got %h want %h", e.name, instr_address, e.addr);
        checks++;
        if (data_out === e.data) passed++;
        else $display("FAIL %s data: got %h want %h", e.name, data_out, e.data);
      end
    end
  end

  // Stimulus
  initial begin
    step(0, 0, 0, 10'h000, 0, 16'h0000, 10'h000, 16'h0000, "reset");
    for (int i = 1; i <= 4; i++)
      step(1, 0, 0, 10'h000, 0, 16'h0000, 10'(i), 16'h0000, "free_run");

    // Reload image: writes land at PCs 0..4 while the PC moves ahead of them.
    step(0, 0, 0, 10'h000, 0, 16'h0000, 10'h000, 16'h0000, "reset2");
    for (int i = 1; i <= 5; i++)
      step(1, 0, 0, 10'h000, 1, 16'h0011, 10'(i), 16'h0000, "load");
    step(0, 0, 0, 10'h000, 0, 16'h0000, 10'h000, 16'h0011, "reset_keeps_mem");
    for (int i = 1; i <= 4; i++)
      step(1, 0, 0, 10'h000, 0, 16'h0000, 10'(i), 16'h0011, "readback");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h005, 16'h0000, "beyond_written");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h006, 16'h0000, "beyond_written");

    // Branch near the top and wrap.
    step(1, 0, 1, 10'h3FE, 0, 16'h0000, 10'h3FE, 16'h0000, "branch");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h3FF, 16'h0000, "top");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h000, 16'h0011, "wrap");

    // Advance to PC=7, then stall over a branch.
    for (int i = 1; i <= 7; i++)
      step(1, 0, 0, 10'h000, 0, 16'h0000, 10'(i), (i <= 4) ? 16'h0011 : 16'h0000, "to_seven");
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 10'h055, 0, 16'h0000, 10'h007, 16'h0000, "stall_over_branch");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h008, 16'h0000, "stall_release");

    // Reset beats stall and branch; the concurrent write still hits PC=8.
    step(0, 1, 1, 10'h055, 1, 16'hA5A5, 10'h000, 16'h0011, "reset_priority");
    step(1, 0, 1, 10'h008, 0, 16'h0000, 10'h008, 16'hA5A5, "write_under_reset");

    // Write under stall is visible immediately and retained.
    step(1, 0, 1, 10'h010, 0, 16'h0000, 10'h010, 16'h0000, "branch_0x10");
    step(1, 1, 0, 10'h000, 1, 16'hBEEF, 10'h010, 16'hBEEF, "write_under_stall");
    step(1, 0, 0, 10'h000, 0, 16'h0000, 10'h011, 16'h0000, "after_stall");
    step(1, 0, 1, 10'h010, 0, 16'h0000, 10'h010, 16'hBEEF, "retained");

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
